// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with per-register
// pending-write (busy) scoreboard for the pipelined RISC-V core.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// Register 0 reads as zero and is never busy. Addresses >= NREG read as
// zero/not-busy and are ignored by writes and issues.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int CW   = $clog2(NREG + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_addr,
   input  logic            flush,
   output logic [CW-1:0]   pend_count
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            wr_ok;
   logic            iss_ok;

   // Non-zero and inside the implemented register range.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (32'(a) < NREG);
   endfunction

   assign wr_ok  = wr_en && addr_ok(wr_addr);
   assign iss_ok = iss_en && addr_ok(iss_addr);

   // Next busy vector: write clears, issue sets (issue wins), flush clears all.
   always_comb begin
      busy_next = busy;
      if (flush) begin
         busy_next = '0;
      end else begin
         if (wr_ok) busy_next[wr_addr] = 1'b0;
         if (iss_ok) busy_next[iss_addr] = 1'b1;
      end
   end

   // State update: data array and busy vector; reset overrides every strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_ok) regs[wr_addr] <= wr_data;
         busy <= busy_next;
      end
   end

   // Combinational read ports with optional bypass from the write port.
   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (addr_ok(rs1_addr)) begin
         rs1_data = regs[rs1_addr];
         rs1_busy = busy[rs1_addr];
      end
      if (addr_ok(rs2_addr)) begin
         rs2_data = regs[rs2_addr];
         rs2_busy = busy[rs2_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rs1_addr)) begin
         rs1_data = wr_data;
         rs1_busy = 1'b0;
      end
      if (wr_ok && (wr_addr == rs2_addr)) begin
         rs2_data = wr_data;
         rs2_busy = 1'b0;
      end
`else
      // Read ports return stored contents only.
`endif
   end

   // Population count of the busy vector.
   always_comb begin
      pend_count = '0;
      for (int i = 0; i < NREG; i++) pend_count = pend_count + CW'(busy[i]);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb, plus hand-written
// sequences for same-cycle bypass behaviour and a non-power-of-2 (NREG=24) instance.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (defaults: XLEN=32, NREG=32)
   logic        reset, wr_en, iss_en, flush;
   logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_addr;
   logic [31:0] wr_data, rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic [5:0]  pend_count;

   regfile_sb dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .pend_count(pend_count)
   );

   // NREG=24 instance
   logic        n_reset, n_wr_en, n_iss_en, n_flush;
   logic [4:0]  n_rs1_addr, n_rs2_addr, n_wr_addr, n_iss_addr;
   logic [31:0] n_wr_data, n_rs1_data, n_rs2_data;
   logic        n_rs1_busy, n_rs2_busy;
   logic [4:0]  n_pend_count;

   regfile_sb #(.XLEN(32), .NREG(24)) dut24 (
      .clk(clk), .reset(n_reset),
      .rs1_addr(n_rs1_addr), .rs2_addr(n_rs2_addr),
      .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
      .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
      .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
      .iss_en(n_iss_en), .iss_addr(n_iss_addr), .flush(n_flush),
      .pend_count(n_pend_count)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ia;
      logic        fl;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      logic [5:0]  pc;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   // Apply one cycle of strobes, release them after the edge, then compare.
   task automatic run_vec(input int k, input vec_t v);
      reset = v.rst; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      iss_en = v.ie; iss_addr = v.ia; flush = v.fl;
      rs1_addr = v.a1; rs2_addr = v.a2;
      @(posedge clk);
      #1;
      reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
      #1;
      check($sformatf("v%0d rs1_data", k), rs1_data, v.d1);
      check($sformatf("v%0d rs1_busy", k), 32'(rs1_busy), 32'(v.b1));
      check($sformatf("v%0d rs2_data", k), rs2_data, v.d2);
      check($sformatf("v%0d rs2_busy", k), 32'(rs2_busy), 32'(v.b2));
      check($sformatf("v%0d pend_count", k), 32'(pend_count), 32'(v.pc));
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
      wr_addr = '0; wr_data = '0; iss_addr = '0; rs1_addr = '0; rs2_addr = '0;
      n_reset = 1'b0; n_wr_en = 1'b0; n_iss_en = 1'b0; n_flush = 1'b0;
      n_wr_addr = '0; n_wr_data = '0; n_iss_addr = '0; n_rs1_addr = '0; n_rs2_addr = '0;

      //           rst we  wa  wd            ie  ia  fl  a1  a2  d1            b1  d2            b2  pc
      vecs[0]  = '{1, 1, 3,  32'h99999999, 1, 4,  0,  0,  5,  32'h0,        0,  32'h0,        0,  0};
      vecs[1]  = '{0, 1, 3,  32'h11111111, 0, 0,  0,  3,  0,  32'h11111111, 0,  32'h0,        0,  0};
      vecs[2]  = '{0, 1, 0,  32'hDEADBEEF, 0, 0,  0,  0,  3,  32'h0,        0,  32'h11111111, 0,  0};
      vecs[3]  = '{0, 0, 0,  32'h0,        1, 5,  0,  5,  3,  32'h0,        1,  32'h11111111, 0,  1};
      vecs[4]  = '{0, 0, 0,  32'h0,        1, 0,  0,  5,  5,  32'h0,        1,  32'h0,        1,  1};
      vecs[5]  = '{0, 1, 5,  32'h12345678, 0, 0,  0,  5,  3,  32'h12345678, 0,  32'h11111111, 0,  0};
      vecs[6]  = '{0, 1, 7,  32'hA5A5A5A5, 1, 7,  0,  7,  5,  32'hA5A5A5A5, 1,  32'h12345678, 0,  1};
      vecs[7]  = '{0, 0, 0,  32'h0,        1, 1,  0,  1,  7,  32'h0,        1,  32'hA5A5A5A5, 1,  2};
      vecs[8]  = '{0, 0, 0,  32'h0,        1, 2,  0,  2,  1,  32'h0,        1,  32'h0,        1,  3};
      vecs[9]  = '{0, 0, 0,  32'h0,        1, 3,  0,  3,  2,  32'h11111111, 1,  32'h0,        1,  4};
      vecs[10] = '{0, 0, 0,  32'h0,        1, 4,  1,  4,  7,  32'h0,        0,  32'hA5A5A5A5, 0,  0};
      vecs[11] = '{0, 1, 3,  32'h33333333, 1, 6,  1,  3,  6,  32'h33333333, 0,  32'h0,        0,  0};
      vecs[12] = '{0, 0, 0,  32'h0,        1, 31, 0,  31, 0,  32'h0,        1,  32'h0,        0,  1};
      vecs[13] = '{0, 0, 0,  32'h0,        1, 31, 0,  31, 5,  32'h0,        1,  32'h12345678, 0,  1};
      vecs[14] = '{1, 1, 9,  32'hCAFEF00D, 1, 10, 0,  3,  31, 32'h0,        0,  32'h0,        0,  0};
      vecs[15] = '{0, 1, 9,  32'h01010101, 1, 9,  0,  9,  5,  32'h01010101, 1,  32'h0,        0,  1};

      @(negedge clk);
      for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

      // Same-cycle read of x9 (old 0x01010101, busy) while writing 0xCAFEF00D.
      @(negedge clk);
      rs1_addr = 5'd9; rs2_addr = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass same-cycle data", rs1_data, 32'hCAFEF00D);
      check("bypass same-cycle busy", 32'(rs1_busy), 32'd0);
`else
      check("no-bypass same-cycle data", rs1_data, 32'h01010101);
      check("no-bypass same-cycle busy", 32'(rs1_busy), 32'd1);
`endif
      check("x0 not bypassed", rs2_data, 32'h0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      #1;
      check("write next-cycle data", rs1_data, 32'hCAFEF00D);
      check("write next-cycle busy", 32'(rs1_busy), 32'd0);
      check("write next-cycle pend", 32'(pend_count), 32'd0);

      // NREG=24: reset, valid write to x23, then write/issue out-of-range addr 30.
      @(negedge clk);
      n_reset = 1'b1;
      @(posedge clk); #1; n_reset = 1'b0;
      n_wr_en = 1'b1; n_wr_addr = 5'd23; n_wr_data = 32'h0BADF00D;
      @(posedge clk); #1;
      n_wr_addr = 5'd30; n_wr_data = 32'h5555AAAA;
      n_iss_en = 1'b1; n_iss_addr = 5'd30;
      @(posedge clk); #1;
      n_wr_en = 1'b0; n_iss_en = 1'b0;
      n_rs1_addr = 5'd30; n_rs2_addr = 5'd23;
      #1;
      check("n24 addr30 data", n_rs1_data, 32'h0);
      check("n24 addr30 busy", 32'(n_rs1_busy), 32'd0);
      check("n24 x23 data", n_rs2_data, 32'h0BADF00D);
      check("n24 pend after oob issue", 32'(n_pend_count), 32'd0);
      n_iss_en = 1'b1; n_iss_addr = 5'd23;
      @(posedge clk); #1;
      n_iss_en = 1'b0;
      #1;
      check("n24 x23 busy", 32'(n_rs2_busy), 32'd1);
      check("n24 pend after x23 issue", 32'(n_pend_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
